// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory controller: access sizes and FSM states.
package dmem_pkg;
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling: merges store data into the old word and
// extracts/extends load data for byte, half and word accesses.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    output logic [31:0] merged,
    output logic [31:0] load_data
);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte  = old_word[{lane, 3'b000} +: 8];
        sel_half  = old_word[{lane[1], 4'b0000} +: 16];
        merged    = old_word;
        load_data = old_word;
        case (size)
            SZ_BYTE: begin
                merged[{lane, 3'b000} +: 8] = store_data[7:0];
                load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                merged[{lane[1], 4'b0000} +: 16] = store_data[15:0];
                load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
            end
            default: begin
                merged    = store_data;
                load_data = old_word;
            end
        endcase
    end
endmodule

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with a combinational fetch port and a handshaked
// data port. Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] OFFSET      = 32'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_address,
    output logic [31:0] instruction,
    input  logic        req,
    input  logic        writeEnable,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] address,
    input  logic [31:0] dataIn,
    output logic        busy,
    output logic        ack,
    output logic [31:0] dataOut,
    output logic        fault
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  WS_LAST = 4'(WAIT_STATES - 1);

    logic [31:0] mem [DEPTH];

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] a_addr, a_data;
    logic [1:0]  a_size;
    logic        a_sext, a_we;

    logic [31:0] pc_off, a_off, old_word, merged, load_data;
    logic        pc_hit, range_bad, access_fault;
    logic [1:0]  lane;
    logic [AW-1:0] widx;

    assign pc_off      = pc_address - OFFSET;
    assign pc_hit      = (pc_address >= OFFSET) && ((pc_off >> 2) < DEPTH_W);
    assign instruction = pc_hit ? mem[pc_off[AW+1:2]] : '0;

    assign a_off     = a_addr - OFFSET;
    assign range_bad = (a_addr < OFFSET) || ((a_off >> 2) >= DEPTH_W);
    assign widx      = a_off[AW+1:2];
    assign old_word  = mem[widx];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((a_size == SZ_HALF) && a_addr[0]) ||
                      ((a_size == SZ_WORD) && (a_addr[1:0] != 2'b00));
    assign access_fault = (a_size == SZ_ILLEGAL) || range_bad || misalign;
    assign lane         = a_addr[1:0];
`else
    // Misaligned halves/words silently drop the offending low address bits.
    assign access_fault = (a_size == SZ_ILLEGAL) || range_bad;
    assign lane         = a_addr[1:0] & {(a_size != SZ_WORD), (a_size == SZ_BYTE)};
`endif

    dmem_lane_align u_align (
        .old_word  (old_word),
        .lane      (lane),
        .size      (a_size),
        .sign_ext  (a_sext),
        .store_data(a_data),
        .merged    (merged),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            fault    <= 1'b0;
            dataOut  <= '0;
            a_addr   <= '0;
            a_data   <= '0;
            a_size   <= SZ_BYTE;
            a_sext   <= 1'b0;
            a_we     <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    a_addr <= address;
                    a_data <= dataIn;
                    a_size <= size;
                    a_sext <= sign_ext;
                    a_we   <= writeEnable;
                    busy   <= 1'b1;
                    if (WAIT_STATES == 0) begin
                        state <= RESP;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WS_LAST;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= RESP;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                RESP: begin
                    ack     <= 1'b1;
                    busy    <= 1'b0;
                    fault   <= access_fault;
                    dataOut <= (access_fault || a_we) ? 32'h0 : load_data;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stores commit on the edge that leaves RESP; reset forces IDLE so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (state == RESP && a_we && !access_fault)
            mem[widx] <= merged;
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: two controllers (0 and 3 wait states) checked every cycle against
// a word-array memory model, plus literal expectations for the key scenarios.
module tb_data_memory_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic [31:0] pc [2], addr [2], din [2], instr [2], dout [2];
    logic        req [2], we [2], sx [2], busy [2], ack [2], fault [2];
    logic [1:0]  sz [2];

    data_memory_ctrl #(.DEPTH(1024), .OFFSET(32'h0), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n[0]), .pc_address(pc[0]), .instruction(instr[0]),
        .req(req[0]), .writeEnable(we[0]), .size(sz[0]), .sign_ext(sx[0]),
        .address(addr[0]), .dataIn(din[0]), .busy(busy[0]), .ack(ack[0]),
        .dataOut(dout[0]), .fault(fault[0]));

    data_memory_ctrl #(.DEPTH(1024), .OFFSET(32'h0), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n[1]), .pc_address(pc[1]), .instruction(instr[1]),
        .req(req[1]), .writeEnable(we[1]), .size(sz[1]), .sign_ext(sx[1]),
        .address(addr[1]), .dataIn(din[1]), .busy(busy[1]), .ack(ack[1]),
        .dataOut(dout[1]), .fault(fault[1]));

    typedef struct {
        bit          v;
        int          acc;
        bit          w;
        logic [1:0]  s;
        bit          x;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    int          total = 0, bad = 0, cyc = 0;
    txn_t        pend [2];
    logic [31:0] mm [2][1024];
    bit          mv [2][1024];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit m_fault(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd3) return 1'b1;
        if ((a / 4) >= 1024) return 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (s == 2'd1 && (a % 2) != 0) return 1'b1;
        if (s == 2'd2 && (a % 4) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_eff(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd1) return a - (a % 2);
        if (s == 2'd2) return a - (a % 4);
        return a;
    endfunction

    function automatic logic [31:0] m_load(input int i, input logic [1:0] s, input bit x, input logic [31:0] a);
        logic [31:0] ea, w, v;
        int k;
        ea = m_eff(s, a);
        w  = mm[i][ea / 4];
        k  = int'(ea % 4);
        if (s == 2'd0) begin
            v = (w >> (8 * k)) % 256;
            if (x && v >= 128) v = v + 32'hFFFFFF00;
        end else if (s == 2'd1) begin
            v = (w >> (8 * k)) % 65536;
            if (x && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic m_store(input int i, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ea, mask;
        int k;
        ea = m_eff(s, a);
        k  = int'(ea % 4);
        if (s == 2'd2) begin
            mm[i][ea / 4] = d;
        end else begin
            mask = ((s == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * k);
            mm[i][ea / 4] = (mm[i][ea / 4] & ~mask) | ((d << (8 * k)) & mask);
        end
        mv[i][ea / 4] = 1'b1;
    endtask

    task automatic cmp(input int i);
        int ws;
        bit eb, ea, f;
        ws = (i == 0) ? 0 : 3;
        if (!rst_n[i]) begin
            pend[i].v = 1'b0;
            check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'h0);
            check($sformatf("rst_ack%0d", i), 32'(ack[i]), 32'h0);
            check($sformatf("rst_fault%0d", i), 32'(fault[i]), 32'h0);
            check($sformatf("rst_dout%0d", i), dout[i], 32'h0);
            return;
        end
        eb = pend[i].v && cyc >= pend[i].acc && cyc <= pend[i].acc + ws;
        ea = pend[i].v && cyc == pend[i].acc + ws + 1;
        check($sformatf("busy%0d@%0d", i, cyc), 32'(busy[i]), 32'(eb));
        check($sformatf("ack%0d@%0d", i, cyc), 32'(ack[i]), 32'(ea));
        if (ea) begin
            f = m_fault(pend[i].s, pend[i].a);
            check($sformatf("fault%0d@%0d", i, cyc), 32'(fault[i]), 32'(f));
            if (f)
                check($sformatf("fdout%0d@%0d", i, cyc), dout[i], 32'h0);
            else if (!pend[i].w)
                check($sformatf("dout%0d@%0d", i, cyc), dout[i], m_load(i, pend[i].s, pend[i].x, pend[i].a));
            else
                m_store(i, pend[i].s, pend[i].a, pend[i].d);
            pend[i].v = 1'b0;
        end
        if (pc[i] >= 32'h1000)
            check($sformatf("instr_oor%0d", i), instr[i], 32'h0);
        else if (mv[i][pc[i] / 4])
            check($sformatf("instr%0d@%0d", i, cyc), instr[i], mm[i][pc[i] / 4]);
    endtask

    always @(negedge clk) begin
        cmp(0);
        cmp(1);
    end

    task automatic access(input int i, input bit w, input logic [1:0] s, input bit x,
                          input logic [31:0] a, input logic [31:0] d, input bit poke,
                          output logic [31:0] rd, output logic rf, output int lat, output int bcnt);
        int acc;
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; sz[i] = s; sx[i] = x; addr[i] = a; din[i] = d;
        @(posedge clk);
        #1;
        req[i] = 1'b0;
        acc = cyc;
        pend[i].acc = acc; pend[i].w = w; pend[i].s = s; pend[i].x = x;
        pend[i].a = a; pend[i].d = d; pend[i].v = 1'b1;
        rd = '0; rf = 1'b0; lat = -1; bcnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (ack[i]) begin
                rd = dout[i]; rf = fault[i]; lat = cyc - acc;
                break;
            end
            if (busy[i]) bcnt++;
            if (poke && cyc == acc + 1) req[i] = 1'b1;
            if (poke && cyc == acc + 2) req[i] = 1'b0;
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL ack_timeout inst%0d addr %h: got no ack want ack", i, a);
        end
    endtask

    logic [31:0] rd;
    logic        rf;
    int          lat, bc;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; pc[i] = '0; req[i] = 1'b0; we[i] = 1'b0; sz[i] = 2'd0;
            sx[i] = 1'b0; addr[i] = '0; din[i] = '0; pend[i].v = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy[0]), 32'h0);
        check("reset_dout", dout[1], 32'h0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // zero wait states: basic word store/load
        access(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, rd, rf, lat, bc);
        check("st_word_lat", 32'(lat), 32'd1);
        access(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, rd, rf, lat, bc);
        check("ld_word", rd, 32'hDEADBEEF);
        check("ld_word_fault", 32'(rf), 32'h0);
        check("ld_word_lat", 32'(lat), 32'd1);

        // byte lane store and sign/zero extension
        access(0, 1, 2'd2, 0, 32'h10, 32'h0, 0, rd, rf, lat, bc);
        access(0, 1, 2'd0, 0, 32'h13, 32'h12345680, 0, rd, rf, lat, bc);
        access(0, 0, 2'd0, 1, 32'h13, 32'h0, 0, rd, rf, lat, bc);
        check("ld_byte_sx", rd, 32'hFFFFFF80);
        access(0, 0, 2'd0, 0, 32'h13, 32'h0, 0, rd, rf, lat, bc);
        check("ld_byte_zx", rd, 32'h00000080);
        access(0, 0, 2'd2, 1, 32'h10, 32'h0, 0, rd, rf, lat, bc);
        check("ld_word_after_byte", rd, 32'h80000000);
        pc[0] = 32'h10;
        @(negedge clk);
        check("fetch_0x10", instr[0], 32'h80000000);

        // half lanes, with fetch watching the word being rewritten
        pc[0] = 32'h20;
        access(0, 1, 2'd2, 0, 32'h20, 32'h12345678, 0, rd, rf, lat, bc);
        access(0, 1, 2'd1, 0, 32'h22, 32'h0000ABCD, 0, rd, rf, lat, bc);
        access(0, 0, 2'd2, 0, 32'h20, 32'h0, 0, rd, rf, lat, bc);
        check("ld_word_after_half", rd, 32'hABCD5678);
        access(0, 0, 2'd1, 1, 32'h22, 32'h0, 0, rd, rf, lat, bc);
        check("ld_half_sx", rd, 32'hFFFFABCD);
        access(0, 0, 2'd1, 1, 32'h20, 32'h0, 0, rd, rf, lat, bc);
        check("ld_half_pos", rd, 32'h00005678);
        access(0, 0, 2'd0, 1, 32'h21, 32'h0, 0, rd, rf, lat, bc);
        check("ld_byte1", rd, 32'h00000056);

        // range and size faults; out-of-range store must not alias word 0
        access(0, 1, 2'd2, 0, 32'h0, 32'hCAFEF00D, 0, rd, rf, lat, bc);
        access(0, 1, 2'd2, 0, 32'h1000, 32'h99, 0, rd, rf, lat, bc);
        check("st_oor_fault", 32'(rf), 32'h1);
        access(0, 0, 2'd2, 0, 32'h0, 32'h0, 0, rd, rf, lat, bc);
        check("word0_intact", rd, 32'hCAFEF00D);
        access(0, 0, 2'd3, 0, 32'h20, 32'h0, 0, rd, rf, lat, bc);
        check("size11_fault", 32'(rf), 32'h1);
        check("size11_dout", rd, 32'h0);
        access(0, 1, 2'd2, 0, 32'hFFC, 32'h5A5A5A5A, 0, rd, rf, lat, bc);
        access(0, 0, 2'd2, 0, 32'hFFC, 32'h0, 0, rd, rf, lat, bc);
        check("last_word", rd, 32'h5A5A5A5A);
        check("last_word_fault", 32'(rf), 32'h0);

        // misaligned accesses
        access(0, 0, 2'd1, 0, 32'h21, 32'h0, 0, rd, rf, lat, bc);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_half_fault", 32'(rf), 32'h1);
        check("mis_half_dout", rd, 32'h0);
`else
        check("mis_half_fault", 32'(rf), 32'h0);
        check("mis_half_dout", rd, 32'h00005678);
`endif
        access(0, 0, 2'd2, 0, 32'h23, 32'h0, 0, rd, rf, lat, bc);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_word_dout", rd, 32'h0);
`else
        check("mis_word_dout", rd, 32'hABCD5678);
`endif
        pc[0] = 32'h1000;
        @(negedge clk);
        check("fetch_oor", instr[0], 32'h0);

        // three wait states: latency, busy window, ignored request while busy
        access(1, 1, 2'd2, 0, 32'h40, 32'h11111111, 0, rd, rf, lat, bc);
        check("ws3_st_lat", 32'(lat), 32'd4);
        access(1, 0, 2'd2, 0, 32'h40, 32'h0, 1, rd, rf, lat, bc);
        check("ws3_ld", rd, 32'h11111111);
        check("ws3_ld_lat", 32'(lat), 32'd4);
        check("ws3_busy_cycles", 32'(bc), 32'd4);
        repeat (4) @(negedge clk);

        // reset in the middle of a store aborts it
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'd2; addr[1] = 32'h40; din[1] = 32'h22222222;
        @(posedge clk); #1;
        req[1] = 1'b0;
        pend[1].acc = cyc; pend[1].w = 1'b1; pend[1].s = 2'd2; pend[1].x = 1'b0;
        pend[1].a = 32'h40; pend[1].d = 32'h22222222; pend[1].v = 1'b1;
        @(negedge clk);
        #2;
        rst_n[1] = 1'b0;
        pend[1].v = 1'b0;
        #1;
        check("abort_busy", 32'(busy[1]), 32'h0);
        check("abort_ack", 32'(ack[1]), 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        access(1, 0, 2'd2, 0, 32'h40, 32'h0, 0, rd, rf, lat, bc);
        check("abort_no_write", rd, 32'h11111111);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
